// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential single-precision FP divider, restoring division, one quotient bit per clock.
// Ports: clk, rst_n (async active-low); start, a (dividend), b (divisor) sampled in IDLE;
//        q (quotient), dbz/ovf/unf flags held until the next result; done (1-cycle pulse); busy.
// Format: value = 0.1f x 2^(e-126); exponent 0 is zero, no denormals, no rounding.
module fp_divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        done,
  output logic        busy,
  output logic        dbz,
  output logic        ovf,
  output logic        unf
);
  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;
  state_t state, state_n;
  logic        s;
  logic [7:0]  ea, eb;
  logic [24:0] r, qr;
  logic [23:0] m, diff;
  logic [4:0]  cnt;
  logic        ge;
  logic [9:0]  e;
  logic [22:0] frac;
  logic [31:0] q_n;
  logic        dbz_n, ovf_n, unf_n;
  assign busy = state != IDLE;
  assign ge   = r >= {1'b0, m};
  // when r >= m the difference is below m, so its low 24 bits are exact
  assign diff = r[23:0] - m;
  // two's-complement exponent; bit 9 is the sign
  assign e    = {2'b00, ea} - {2'b00, eb} + 10'd126 + {9'd0, qr[24]};
  assign frac = qr[24] ? qr[23:1] : qr[22:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? CALC : IDLE) :
              (state == CALC) ? (cnt == 5'd24 ? NORM : CALC) : IDLE;
  end
  always_comb begin
    q_n   = {s, e[7:0], frac};
    dbz_n = 1'b0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    if (eb == 8'd0 && ea == 8'd0) begin
      q_n   = 32'h7FC00000;
      dbz_n = 1'b1;
    end else if (eb == 8'd0) begin
      q_n   = {s, 8'hFF, 23'h0};
      dbz_n = 1'b1;
    end else if (ea == 8'd0) begin
      q_n   = {s, 31'h0};
    end else if (!e[9] && e >= 10'd255) begin
      q_n   = {s, 8'hFF, 23'h0};
      ovf_n = 1'b1;
    end else if (e[9] || e == 10'd0) begin
      q_n   = {s, 31'h0};
      unf_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s    <= 1'b0;
      ea   <= 8'd0;
      eb   <= 8'd0;
      r    <= 25'd0;
      m    <= 24'd0;
      qr   <= 25'd0;
      cnt  <= 5'd0;
      q    <= 32'd0;
      done <= 1'b0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      done <= state == NORM;
      if (state == IDLE && start) begin
        s   <= a[31] ^ b[31];
        ea  <= a[30:23];
        eb  <= b[30:23];
        r   <= {2'b01, a[22:0]};
        m   <= {1'b1, b[22:0]};
        qr  <= 25'd0;
        cnt <= 5'd0;
      end
      if (state == CALC) begin
        qr  <= {qr[23:0], ge};
        r   <= ge ? {diff, 1'b0} : {r[23:0], 1'b0};
        cnt <= cnt + 5'd1;
      end
      if (state == NORM) begin
        q   <= q_n;
        dbz <= dbz_n;
        ovf <= ovf_n;
        unf <= unf_n;
      end
    end
endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: directed bench with a cycle-level reference model for fp_divider_seq.
module tb_fp_divider_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [31:0] q;
  logic        done, busy, dbz, ovf, unf;
  int n_vec = 0, n_err = 0;

  fp_divider_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .q(q), .done(done), .busy(busy), .dbz(dbz), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: exact integer quotient of the 24-bit mantissas, then the exponent/special rules
  function automatic logic [34:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic        sg;
    logic [63:0] num, den, qq;
    logic [22:0] fr;
    int ex, ey, e, sh;
    sg  = x[31] ^ y[31];
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    num = {40'd1, x[22:0]} << 24;
    den = {40'd1, y[22:0]};
    qq  = num / den;
    sh  = (qq >= 64'h1000000) ? 1 : 0;
    fr  = sh == 1 ? qq[23:1] : qq[22:0];
    e   = ex - ey + 126 + sh;
    if (ex == 0 && ey == 0) return {32'h7FC00000, 3'b100};
    if (ey == 0) return {sg, 8'hFF, 23'h0, 3'b100};
    if (ex == 0) return {sg, 31'h0, 3'b000};
    if (e >= 255) return {sg, 8'hFF, 23'h0, 3'b010};
    if (e <= 0) return {sg, 31'h0, 3'b001};
    return {sg, 8'(e), fr, 3'b000};
  endfunction

  // model: an accepted request produces its result exactly 26 edges later
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_q = 32'd0;
  logic [2:0]  m_f = 3'd0;
  logic [34:0] pend = 35'd0;
  int          m_cnt = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_q = 32'd0; m_f = 3'd0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 26) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_q, m_f} = pend;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        pend   = ref_div(a, b);
      end
    end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("q", q, m_q);
    chk("flags", {29'd0, dbz, ovf, unf}, {29'd0, m_f});
  end

  task automatic op(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] eq,
                    input logic [2:0] ef, input string nm, input bit poke);
    int lat;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      start = poke && (lat == 5 || lat == 20);
      if (done) break;
    end
    start = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'd26);
    chk({nm, " q"}, q, eq);
    chk({nm, " flags"}, {29'd0, dbz, ovf, unf}, {29'd0, ef});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd;
    #1 rst_n = 1'b0;
    #2 chk("reset q", q, 32'd0);
    chk("reset ctl", {28'd0, busy, done, dbz, ovf, unf}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    op(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "6/2", 1'b0);
    op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, "1/3", 1'b0);
    op(32'hBFC00000, 32'h3F000000, 32'hC0400000, 3'b000, "-1.5/0.5", 1'b0);
    op(32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100, "1/0", 1'b0);
    op(32'h00000000, 32'h00000000, 32'h7FC00000, 3'b100, "0/0", 1'b0);
    op(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, "-0/1", 1'b0);
    op(32'h7F000000, 32'h00800000, 32'h7F800000, 3'b010, "ovf", 1'b0);
    op(32'h00800000, 32'h7F000000, 32'h00000000, 3'b001, "unf", 1'b0);
    op(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "poke", 1'b1);
    op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, "b2b", 1'b0);
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midrst q", q, 32'd0);
    chk("midrst ctl", {28'd0, busy, done, dbz, ovf, unf}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("midrst no done", 32'(nd), 32'd0);
    op(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "after rst", 1'b0);
    op(32'hC1200000, 32'hC0800000, 32'h40200000, 3'b000, "-10/-4", 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
